// File: rtl/clk_gate_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_gate_ctrl_pkg                                                |
// | Brief   : Shared types, widths and parameter checks for clk_gate_ctrl.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } clk_gate_state_e;

  localparam int StatsWidth = 32;

  // One counter serves both intervals, so size it for the longer one.
  function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
    int m;
    m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int idle_cycles, input int wake_cycles);
    return (idle_cycles >= 1) && (idle_cycles <= 65535) &&
           (wake_cycles >= 0) && (wake_cycles <= 255);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate_ctrl_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_gate_ctrl_cnt                                                |
// | Brief   : Clear/increment interval counter with terminal-count compare.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_gate_ctrl_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             at_term_o
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment so a state change always restarts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign at_term_o = (r_count == term_i);

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_gate_ctrl                                                    |
// | Brief   : ICG enable controller: idle gate-off, req wake-up, settle grant. |
// |           Optional gated-cycle statistics under CLK_GATE_CTRL_STATS_EN.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  busy_i,
`ifdef CLK_GATE_CTRL_STATS_EN
  input  logic                  clr_stats_i,
  output logic [StatsWidth-1:0] gated_cycles_o,
`endif
  output logic                  gnt_o,
  output logic                  clk_en_o,
  output logic                  gated_o
);

  localparam int                c_cnt_w     = cnt_width(IdleCycles, WakeCycles);
  localparam logic [c_cnt_w-1:0] c_idle_term = c_cnt_w'(IdleCycles - 1);
  localparam logic [c_cnt_w-1:0] c_wake_term = c_cnt_w'((WakeCycles == 0) ? 0 : WakeCycles - 1);

  clk_gate_state_e    r_state;
  logic               r_gnt;
  logic               r_clk_en;
  logic               r_gated;
  logic               w_idle;
  logic               w_at_term;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic [c_cnt_w-1:0] w_cnt_term;

  assign w_idle     = !req_i && !busy_i;
  assign w_cnt_term = (r_state == WAKE) ? c_wake_term : c_idle_term;

  always_comb begin
    w_cnt_clr = 1'b1;
    w_cnt_inc = 1'b0;
    case (r_state)
      RUN: begin
        w_cnt_clr = !w_idle || w_at_term;
        w_cnt_inc = w_idle && !w_at_term;
      end
      WAKE: begin
        w_cnt_clr = w_at_term;
        w_cnt_inc = !w_at_term;
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_cnt_inc = 1'b0;
      end
    endcase
  end

  clk_gate_ctrl_cnt #(
    .WIDTH (c_cnt_w)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (w_cnt_clr),
    .inc_i     (w_cnt_inc),
    .term_i    (w_cnt_term),
    .at_term_o (w_at_term)
  );

  // Outputs are loaded alongside the state so they stay pure flop outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= RUN;
      r_clk_en <= 1'b1;
      r_gnt    <= 1'b1;
      r_gated  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_idle && w_at_term) begin
            r_state  <= GATED;
            r_clk_en <= 1'b0;
            r_gnt    <= 1'b0;
            r_gated  <= 1'b1;
          end
        end
        GATED: begin
          if (!w_idle) begin
            r_clk_en <= 1'b1;
            r_gated  <= 1'b0;
            if (WakeCycles == 0) begin
              r_state <= RUN;
              r_gnt   <= 1'b1;
            end else begin
              r_state <= WAKE;
              r_gnt   <= 1'b0;
            end
          end
        end
        WAKE: begin
          if (w_at_term) begin
            r_state <= RUN;
            r_gnt   <= 1'b1;
          end
        end
        default: begin
          r_state  <= RUN;
          r_clk_en <= 1'b1;
          r_gnt    <= 1'b1;
          r_gated  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o    = r_gnt;
  assign clk_en_o = r_clk_en;
  assign gated_o  = r_gated;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [StatsWidth-1:0] r_gated_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gated_cycles <= '0;
    end else if (clr_stats_i) begin
      r_gated_cycles <= '0;
    end else if (!r_clk_en && !(&r_gated_cycles)) begin
      r_gated_cycles <= r_gated_cycles + StatsWidth'(1);
    end
  end

  assign gated_cycles_o = r_gated_cycles;
`endif

`ifndef SYNTHESIS
  a_params_ok: assert property (@(posedge clk_i) params_ok(IdleCycles, WakeCycles));

  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> req_i);

  a_gnt_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == RUN && req_i) |=> gnt_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_clk_gate_ctrl                                                 |
// | Brief   : Directed + randomized bench for clk_gate_ctrl against a model.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_clk_gate_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        busy;
  logic        gnt;
  logic        clk_en;
  logic        gated;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic        clr_stats;
  logic [31:0] gated_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "off" flag, remaining settle cycles, current idle streak.
  bit          m_off;
  int          m_settle_left;
  int          m_idle_streak;
  logic [31:0] m_stats;

  logic        gnt_pre;
  logic        req_lock;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IdleCycles (IDLE),
    .WakeCycles (WAKE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .busy_i         (busy),
`ifdef CLK_GATE_CTRL_STATS_EN
    .clr_stats_i    (clr_stats),
    .gated_cycles_o (gated_cycles),
`endif
    .gnt_o          (gnt),
    .clk_en_o       (clk_en),
    .gated_o        (gated)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off         = 1'b0;
    m_settle_left = 0;
    m_idle_streak = 0;
    m_stats       = '0;
  endtask

  task automatic model_edge();
`ifdef CLK_GATE_CTRL_STATS_EN
    if (clr_stats)                          m_stats = '0;
    else if (m_off && m_stats != 32'hFFFF_FFFF) m_stats = m_stats + 1;
`endif
    if (m_off) begin
      if (req || busy) begin
        m_off         = 1'b0;
        m_settle_left = WAKE;
      end
    end else if (m_settle_left > 0) begin
      m_settle_left--;
    end else if (!req && !busy) begin
      m_idle_streak++;
      if (m_idle_streak == IDLE) begin
        m_off         = 1'b1;
        m_idle_streak = 0;
      end
    end else begin
      m_idle_streak = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("clk_en", clk_en, !m_off);
    check_eq("gnt", gnt, !m_off && m_settle_left == 0);
    check_eq("gated", gated, m_off);
`ifdef CLK_GATE_CTRL_STATS_EN
    check_eq("gated_cycles", gated_cycles, m_stats);
`endif
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    gnt_pre = gnt;
    @(posedge clk);
    #1;
    req_lock = req && !gnt_pre && rst_n;
    if (!rst_n) model_reset();
    else        model_edge();
    check_outputs();
  endtask

  task automatic release_req();
    for (int i = 0; i < 20 && req_lock; i++) step();
    check_eq("req_release_bound", req_lock, 1'b0);
    req = 1'b0;
  endtask

  task automatic idle_until_gated(output int n);
    n = 0;
    while (!gated && n < 40) begin
      step();
      n++;
    end
    check_eq("gate_bound", gated, 1'b1);
  endtask

  initial begin : stim
    int  n;
    bit  never_gated;
    bit  quiet;
    int  p;

    rst_n    = 1'b0;
    req      = 1'b0;
    busy     = 1'b0;
    req_lock = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    clr_stats = 1'b0;
`endif
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_eq("rst_clk_en", clk_en, 1'b1);
    check_eq("rst_gnt", gnt, 1'b1);
    rst_n = 1'b1;

    // Gate-off after exactly IDLE idle cycles
    idle_until_gated(n);
    check_eq("gate_latency", n, IDLE);

    // Wake: en at t+1, gnt at t+1+WAKE, then gnt held while req held
    req = 1'b1;
    step();
    check_eq("wake_en_t1", clk_en, 1'b1);
    check_eq("wake_gnt_t1", gnt, 1'b0);
    step();
    check_eq("wake_gnt_t2", gnt, 1'b0);
    step();
    check_eq("wake_gnt_t3", gnt, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("gnt_held", gnt, 1'b1);
    end
    release_req();

    // busy every third cycle never lets the idle count reach IDLE
    never_gated = 1'b1;
    for (int i = 0; i < 30; i++) begin
      busy = (i % 3 == 0);
      step();
      if (!clk_en) never_gated = 1'b0;
    end
    check_eq("busy_pulse_no_gate", never_gated, 1'b1);

    // busy arriving on the terminal idle cycle keeps the block running
    busy = 1'b1;
    step();
    busy = 1'b0;
    repeat (IDLE - 1) step();
    busy = 1'b1;
    step();
    check_eq("term_busy_en", clk_en, 1'b1);
    busy = 1'b0;
    repeat (IDLE - 1) step();
    check_eq("term_busy_still_on", clk_en, 1'b1);
    step();
    check_eq("term_busy_then_gate", clk_en, 1'b0);

    // Asynchronous reset in WAKE
    req = 1'b1;
    step();
    check_eq("in_wake_gnt", gnt, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_clk_en", clk_en, 1'b1);
    check_eq("async_rst_gnt", gnt, 1'b1);
    check_eq("async_rst_gated", gated, 1'b0);
    step();
    req   = 1'b0;
    rst_n = 1'b1;

`ifdef CLK_GATE_CTRL_STATS_EN
    // Ten gated cycles, then clear
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    idle_until_gated(n);
    repeat (9) step();
    req = 1'b1;
    step();
    check_eq("stats_ten", gated_cycles, 32'd10);
    release_req();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check_eq("stats_clr", gated_cycles, 32'd0);
`endif

    // Randomized phases alternating quiet and busy traffic
    quiet = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) quiet = 1'($urandom_range(0, 1));
      p = quiet ? 4 : 50;
      req  = req_lock ? 1'b1 : ($urandom_range(0, 99) < p);
      busy = ($urandom_range(0, 99) < p);
`ifdef CLK_GATE_CTRL_STATS_EN
      clr_stats = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
